// File: rtl/i2c_byte_sequencer.sv
// rtl/i2c_byte_sequencer.sv - single-transaction I2C master byte sequencer
// Drives SCL, the master data bit and the SDA selector lines for START/ADDR/ACK/DATA/ACK/STOP.
module i2c_byte_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       scl,
  output logic       sda_o,
  input  logic       sda_i,
  output logic       sel_rw,
  output logic       sel_ack,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_t;

  localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic          samp_q, samp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic [7:0]    rdata_q, rdata_d;

  logic qtr_end, slot_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    samp_d  = samp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nack_d  = nack_q;
    rdata_d = rdata_q;

    qtr_end  = (div_q == DIV_MAX);
    slot_end = qtr_end && (qtr_q == 2'd3);

    if (state_q != S_IDLE) begin
      div_d = qtr_end ? '0 : div_q + 1'b1;
      if (qtr_end) qtr_d = qtr_q + 2'd1;
      if (qtr_end && (qtr_q == 2'd2)) samp_d = sda_i;
    end

    // Decisions are made on the last cycle of a slot, using the sample from its Q2.
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_START;
          div_d   = '0;
          qtr_d   = '0;
          shift_d = {cmd_addr, cmd_rw};
          wdata_d = cmd_wdata;
          rw_d    = cmd_rw;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_ADDR;
          bit_d   = 3'd7;
        end
      end
      S_ADDR: begin
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = S_AACK;
            shift_d = wdata_q;
          end else begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], samp_q};
          end
        end
      end
      S_AACK: begin
        if (slot_end) begin
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
            bit_d   = 3'd7;
          end
        end
      end
      S_DATA: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], samp_q};
          if (bit_q == 3'd0) begin
            state_d = S_DACK;
            if (rw_q) rdata_d = {shift_q[6:0], samp_q};
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_DACK: begin
        if (slot_end) begin
          if (!rw_q && samp_q) nack_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl     = 1'b1;
    sda_o   = 1'b1;
    sel_rw  = 1'b0;
    sel_ack = 1'b0;
    case (state_q)
      S_START: sda_o = ~qtr_q[1];
      S_ADDR: begin
        scl   = qtr_q[1];
        sda_o = shift_q[7];
      end
      S_AACK: begin
        scl     = qtr_q[1];
        sel_ack = 1'b1;
        sel_rw  = 1'b1;
      end
      S_DATA: begin
        scl = qtr_q[1];
        if (rw_q) sel_rw = 1'b1;
        else      sda_o  = shift_q[7];
      end
      // Read ends with a master NACK; write samples the slave ACK.
      S_DACK: begin
        scl     = qtr_q[1];
        sel_ack = 1'b1;
        sel_rw  = ~rw_q;
      end
      S_STOP: begin
        scl   = qtr_q[1];
        sda_o = (qtr_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb/tb_i2c_byte_sequencer.sv - self-checking bench for i2c_byte_sequencer
// Table-driven commands with a scoreboard queue, plus reset, back-to-back and CLK_DIV=1 sequences.
module tb_i2c_byte_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       scl, sda_o, sda_i, sel_rw, sel_ack, busy, done, nack;
  logic [7:0] rdata;

  logic       c1_valid, c1_ready, c1_scl, c1_sda_o, c1_sda_i, c1_sel_rw, c1_sel_ack;
  logic       c1_busy, c1_done, c1_nack;
  logic [7:0] c1_rdata;

  always #5 clk = ~clk;

  i2c_byte_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .scl(scl), .sda_o(sda_o), .sda_i(sda_i), .sel_rw(sel_rw), .sel_ack(sel_ack),
    .busy(busy), .done(done), .nack(nack), .rdata(rdata)
  );

  i2c_byte_sequencer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_addr(7'h10), .cmd_rw(1'b0), .cmd_wdata(8'h3C),
    .scl(c1_scl), .sda_o(c1_sda_o), .sda_i(c1_sda_i), .sel_rw(c1_sel_rw), .sel_ack(c1_sel_ack),
    .busy(c1_busy), .done(c1_done), .nack(c1_nack), .rdata(c1_rdata)
  );

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rbyte;
    logic       aack;
    logic       dack;
    logic       exp_nack;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic       rw;
    logic       aack;
    logic       dack;
    logic [7:0] rbyte;
    logic       nack;
    logic [7:0] rdata;
    int         lat;
    int         pulses;
    logic [7:0] abyte;
    logic [7:0] dbyte;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model_rdata;

  int         lat, fc, pc, idx, acc_cnt;
  logic       scl_prev, phase_ok, b2b_seen;
  logic [7:0] abyte, dbyte;
  logic       s_aack, s_dack, cur_rw, cur_aack;
  logic [7:0] s_rbyte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: slot index counts SCL falling edges since the accept.
  function automatic logic slave_bit(input int f, input logic a, input logic d, input logic [7:0] r);
    if (f == 9) return a;
    if (f >= 10 && f <= 17) return r[17 - f];
    if (f == 18) return d;
    return 1'b1;
  endfunction

  assign sda_i = slave_bit(fc, s_aack, s_dack, s_rbyte);

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no transaction pending");
      end else begin
        e = sb.pop_front();
        check("nack", 32'(nack), 32'(e.nack));
        check("rdata", 32'(rdata), 32'(e.rdata));
        check("latency", 32'(lat), 32'(e.lat));
        check("scl_pulses", 32'(pc), 32'(e.pulses));
        check("addr_byte", 32'(abyte), 32'(e.abyte));
        check("phase_select", 32'(phase_ok), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        if (!e.rw && !e.aack) check("data_byte", 32'(dbyte), 32'(e.dbyte));
      end
    end
    if (scl && !scl_prev) begin
      idx = pc;
      pc++;
      if (idx < 8) begin
        abyte    = {abyte[6:0], sda_o};
        phase_ok &= ({sel_ack, sel_rw} == 2'b00);
      end else if (idx == 8) begin
        phase_ok &= ({sel_ack, sel_rw} == 2'b11);
      end else if (!cur_aack && idx <= 16) begin
        if (cur_rw) phase_ok &= ({sel_ack, sel_rw} == 2'b01);
        else begin
          dbyte    = {dbyte[6:0], sda_o};
          phase_ok &= ({sel_ack, sel_rw} == 2'b00);
        end
      end else if (!cur_aack && idx == 17) begin
        if (cur_rw) phase_ok &= ({sel_ack, sel_rw} == 2'b10) && sda_o;
        else        phase_ok &= ({sel_ack, sel_rw} == 2'b11);
      end else begin
        phase_ok &= ({sel_ack, sel_rw} == 2'b00);
      end
    end
    if (!scl && scl_prev) fc++;
    scl_prev = scl;
    if (cmd_valid && cmd_ready) begin
      b2b_seen = done;
      lat      = 1;
      fc       = 0;
      pc       = 0;
      abyte    = '0;
      dbyte    = '0;
      phase_ok = 1'b1;
      acc_cnt++;
      if (sb.size() > 0) begin
        s_aack   = sb[0].aack;
        s_dack   = sb[0].dack;
        s_rbyte  = sb[0].rbyte;
        cur_rw   = sb[0].rw;
        cur_aack = sb[0].aack;
      end else begin
        s_aack   = 1'b0;
        s_dack   = 1'b0;
        s_rbyte  = '0;
        cur_rw   = 1'b0;
        cur_aack = 1'b0;
      end
    end else begin
      lat++;
    end
  end

  task automatic send(input vec_t v, input bit hold);
    exp_t x;
    int   a0;
    x.rw     = v.rw;
    x.aack   = v.aack;
    x.dack   = v.dack;
    x.rbyte  = v.rbyte;
    x.nack   = v.exp_nack;
    x.lat    = v.exp_lat;
    x.rdata  = (v.rw && !v.aack) ? v.rbyte : model_rdata;
    model_rdata = x.rdata;
    x.pulses = v.aack ? 10 : 19;
    x.abyte  = {v.addr, v.rw};
    x.dbyte  = v.wdata;
    @(posedge clk);
    #1;
    cmd_addr  = v.addr;
    cmd_rw    = v.rw;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    sb.push_back(x);
    a0 = acc_cnt;
    for (int i = 0; i < 2000 && acc_cnt == a0; i++) @(posedge clk);
    if (acc_cnt == a0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept, expected accept within 2000 cycles");
    end
    if (!hold) begin
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_div1(input logic ack_bit, input int exp_lat, input logic exp_nack);
    int n;
    c1_sda_i = ack_bit;
    @(posedge clk);
    #1 c1_valid = 1'b1;
    @(posedge clk);
    #1 c1_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (c1_done) break;
      @(posedge clk);
      n++;
    end
    check("div1_latency", 32'(n), 32'(exp_lat));
    check("div1_nack", 32'(c1_nack), 32'(exp_nack));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0;
    c1_valid = 1'b0; c1_sda_i = 1'b0;
    lat = 0; fc = 0; pc = 0; idx = 0; acc_cnt = 0; scl_prev = 1'b1; phase_ok = 1'b1;
    b2b_seen = 1'b0; abyte = '0; dbyte = '0; s_aack = 1'b0; s_dack = 1'b0; s_rbyte = '0;
    cur_rw = 1'b0; cur_aack = 1'b0; model_rdata = '0;

    vecs[0] = '{7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 321};
    vecs[1] = '{7'h3C, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0, 1'b0, 321};
    vecs[2] = '{7'h22, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 177};
    vecs[3] = '{7'h7F, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 321};
    vecs[4] = '{7'h3C, 1'b1, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b1, 177};
    vecs[5] = '{7'h01, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 321};
    vecs[6] = '{7'h2A, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0, 321};
    vecs[7] = '{7'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 321};

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_sel", 32'({sel_ack, sel_rw}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i], 1'b0);
      wait_idle();
    end

    // Reset during address bit 3, which is the fifth address slot.
    @(posedge clk);
    #1;
    cmd_addr = 7'h55; cmd_rw = 1'b0; cmd_wdata = 8'h00; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 500 && fc != 5; i++) @(posedge clk);
    check("reach_addr_bit3", 32'(fc), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_scl", 32'(scl), 32'd1);
    check("async_rst_sda_o", 32'(sda_o), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rdata", 32'(rdata), 32'd0);
    model_rdata = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(vecs[0], 1'b1);
    send(vecs[1], 1'b0);
    wait_idle();
    check("back_to_back_accept_on_done", 32'(b2b_seen), 32'd1);

    run_div1(1'b0, 81, 1'b0);
    run_div1(1'b1, 45, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
